// File: rtl/serial_adder_if.sv
// Operand/result bundle between the operand-entry logic and the bit-serial adder.
// The master side issues operations and the slave side (the adder) returns results.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: two half-adder cells plus an OR make a full adder,
// fed LSB-first from operand shift registers with a registered carry.
module HalfAdder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_aSr;
    logic [WIDTH-1:0] r_bSr;
    logic [WIDTH-1:0] r_sumSr;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s1;
    logic             w_c1;
    logic             w_s;
    logic             w_c2;
    logic             w_newCarry;
    logic             w_lastBit;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_msbIn;
    logic [WIDTH-1:0] w_sumShifted;

    HalfAdder u_ha1 (
        .i_a (r_aSr[0]),
        .i_b (r_bSr[0]),
        .o_s (w_s1),
        .o_c (w_c1)
    );

    HalfAdder u_ha2 (
        .i_a (w_s1),
        .i_b (r_carry),
        .o_s (w_s),
        .o_c (w_c2)
    );

    assign w_newCarry = w_c1 | w_c2;
    assign w_lastBit  = (r_cnt == CNT_W'(WIDTH - 1));

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case
    always_comb begin
        w_msbIn            = '0;
        w_msbIn[WIDTH-1]   = w_s;
        w_sumShifted       = (r_sumSr >> 1) | w_msbIn;
    end

    always_comb begin
        w_stateNext = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_stateNext = SHIFT;
                end
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (w_lastBit) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Result registers only move on the completion edge, so partial sums never reach the outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_aSr   <= '0;
            r_bSr   <= '0;
            r_sumSr <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_aSr   <= bus.a;
                        r_bSr   <= bus.b;
                        r_carry <= bus.cin;
                        r_sumSr <= '0;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_aSr   <= r_aSr >> 1;
                    r_bSr   <= r_bSr >> 1;
                    r_sumSr <= w_sumShifted;
                    r_carry <= w_newCarry;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_lastBit) begin
                        r_sum  <= w_sumShifted;
                        r_cout <= w_newCarry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a posedge reference model queues expected
// results and timing, a negedge monitor pops them whenever done is seen.
module tb_serial_adder;
    localparam int W = 8;

    typedef struct {
        logic [W:0] res;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int         nVectors    = 0;
    int         nMiscompares = 0;
    int         cycle       = 0;
    int         nextFree    = 0;
    int         rModel;
    bit         armed       = 1'b0;
    bit         resetSeen   = 1'b0;
    logic [W:0] heldExp     = '0;
    exp_t       eMon;
    exp_t       sbQ[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model: an adder accepts a request only when its previous op has fully drained
    always @(posedge clk) begin
        cycle++;
        resetSeen = reset;
        if (reset) begin
            sbQ.delete();
            nextFree = cycle + 1;
            armed    = 1'b1;
        end else if (bus8.start && cycle >= nextFree) begin
            rModel = int'(bus8.a) + int'(bus8.b) + int'(bus8.cin);
            sbQ.push_back('{res: rModel[W:0], acc: cycle});
            nextFree = cycle + W + 2;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (resetSeen) begin
                heldExp = '0;
            end
            if (bus8.done === 1'b1) begin
                if (sbQ.size() == 0) begin
                    checkOutput("done_unexpected", 64'(bus8.done), 64'd0);
                end else begin
                    eMon = sbQ.pop_front();
                    checkOutput("done_latency", 64'(cycle - eMon.acc), 64'(W));
                    heldExp = eMon.res;
                end
            end else if (sbQ.size() != 0 && cycle >= sbQ[0].acc + W) begin
                checkOutput("done_missing", 64'(bus8.done), 64'd1);
                void'(sbQ.pop_front());
            end
            checkOutput("busy", 64'(bus8.busy), 64'(cycle + 1 < nextFree));
            checkOutput("sum", 64'(bus8.sum), 64'(heldExp[W-1:0]));
            checkOutput("cout", 64'(bus8.cout), 64'(heldExp[W]));
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int hold);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = cin;
        repeat (hold) @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = W'($urandom);
        bus8.b     = W'($urandom);
        bus8.cin   = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    // WIDTH=1 instance: every input combination, done expected one edge after acceptance
    task automatic runWidthOne();
        int total;
        for (int i = 0; i < 8; i++) begin
            total = (i % 2) + ((i / 2) % 2) + (i / 4);
            @(negedge clk);
            bus1.start = 1'b1;
            bus1.a     = 1'(i % 2);
            bus1.b     = 1'((i / 2) % 2);
            bus1.cin   = 1'(i / 4);
            @(negedge clk);
            bus1.start = 1'b0;
            bus1.a     = 1'($urandom);
            bus1.b     = 1'($urandom);
            checkOutput("w1_done_early", 64'(bus1.done), 64'd0);
            checkOutput("w1_busy", 64'(bus1.busy), 64'd1);
            @(negedge clk);
            checkOutput("w1_done", 64'(bus1.done), 64'd1);
            checkOutput("w1_sum", 64'(bus1.sum), 64'(total % 2));
            checkOutput("w1_cout", 64'(bus1.cout), 64'(total / 2));
            @(negedge clk);
            checkOutput("w1_done_once", 64'(bus1.done), 64'd0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus8.cin   = 1'b0;
        bus1.start = 1'b0;
        bus1.a     = 1'b0;
        bus1.b     = 1'b0;
        bus1.cin   = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(2);

        applyStimulus(8'h5A, 8'h33, 1'b0, 1);
        idle(12);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1);
        idle(12);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1);
        idle(12);

        applyStimulus(8'h10, 8'h20, 1'b0, 1);
        idle(1);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1);
        idle(14);

        applyStimulus(8'hAA, 8'h55, 1'b0, 1);
        idle(3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        applyStimulus(8'hAA, 8'h55, 1'b0, 1);
        idle(12);

        applyStimulus(8'h01, 8'h02, 1'b0, 30);
        idle(12);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(pickOperand(), pickOperand(), 1'($urandom), $urandom_range(1, 3));
            idle($urandom_range(0, 12));
        end
        idle(W + 4);

        runWidthOne();
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
